ddr3_burst_tester: RTL and testbench

- Self-checking traffic generator on the mem_clk domain. Drives the rd_burst/wr_burst user interface of the DDR3 controller wrapper.
- After calibration it writes one burst of an address-derived pattern, reads the same burst back and compares every beat.
- It then advances the address, wrapping across the test region. Error and pass counters feed board LEDs and a logic analyser.

---
 rtl/ddr3_burst_tester.sv | 200 ++++++++++++++++++++
 tb/tb_ddr3_burst_tester.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_tester.sv
// Self-checking DDR3 traffic generator: writes an address-derived pattern burst, reads it back,
// compares every beat and walks the test region, tracking error and pass counts.
module ddr3_burst_tester #(
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned BURST_LEN     = 128,
    parameter int unsigned ADDR_LIMIT    = 'h100000
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     calib_done,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     error,
    output logic                     error_flag,
    output logic [15:0]              error_cnt,
    output logic [15:0]              pass_cnt,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StCheck = 2'd3
    } state_e;

    localparam int unsigned          Reps       = MEM_DATA_BITS / 16;
    localparam logic [ADDR_BITS:0]   BurstStep  = (ADDR_BITS + 1)'(BURST_LEN);
    localparam logic [ADDR_BITS:0]   AddrLimit  = (ADDR_BITS + 1)'(ADDR_LIMIT);
    localparam logic [15:0]          BurstBeats = 16'(BURST_LEN);

    // Beat k of the burst at address a: low 16 bits of (a + k), inverted on odd passes.
    function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [15:0] a,
                                                         input logic [15:0] k,
                                                         input logic        par);
        logic [15:0] w;
        w = (a + k) ^ {16{par}};
        return {Reps{w}};
    endfunction

    state_e                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic                     parity_q, parity_d;
    logic [15:0]              wr_beat_q, wr_beat_d;
    logic [15:0]              rd_beat_q, rd_beat_d;
    logic                     wr_req_q, wr_req_d;
    logic                     rd_req_q, rd_req_d;
    logic [ADDR_BITS-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_BITS-1:0]     rd_addr_q, rd_addr_d;
    logic [MEM_DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                     error_q, error_d;
    logic                     error_flag_q, error_flag_d;
    logic [15:0]              error_cnt_q, error_cnt_d;
    logic [15:0]              pass_cnt_q, pass_cnt_d;
    logic [ADDR_BITS:0]       next_addr;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        parity_d     = parity_q;
        wr_beat_d    = wr_beat_q;
        rd_beat_d    = rd_beat_q;
        wr_req_d     = wr_req_q;
        rd_req_d     = rd_req_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        error_d      = 1'b0;
        error_flag_d = error_flag_q;
        error_cnt_d  = error_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        next_addr    = {1'b0, addr_q} + BurstStep;

        case (state_q)
            StIdle: begin
                if (calib_done) begin
                    state_d   = StWrite;
                    wr_req_d  = 1'b1;
                    wr_addr_d = addr_q;
                    wr_beat_d = 16'd0;
                    wr_data_d = pattern(16'(addr_q), 16'd0, parity_q);
                end
            end
            StWrite: begin
                if (wr_burst_data_req) begin
                    wr_beat_d = wr_beat_q + 16'd1;
                    wr_data_d = pattern(16'(addr_q), wr_beat_q + 16'd1, parity_q);
                end
                if (wr_burst_finish) begin
                    wr_req_d  = 1'b0;
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q;
                    state_d   = StRead;
                end
            end
            StRead: begin
                // A beat arriving alongside finish is still checked.
                if (rd_burst_data_valid) begin
                    if (rd_burst_data != pattern(16'(addr_q), rd_beat_q, parity_q)) begin
                        error_d = 1'b1;
                    end
                    rd_beat_d = rd_beat_q + 16'd1;
                end
                if (rd_burst_finish) begin
                    rd_req_d = 1'b0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (rd_beat_q != BurstBeats) begin
                    error_d = 1'b1;
                end
                wr_beat_d = 16'd0;
                rd_beat_d = 16'd0;
                if (next_addr >= AddrLimit) begin
                    addr_d     = '0;
                    parity_d   = ~parity_q;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end else begin
                    addr_d = next_addr[ADDR_BITS-1:0];
                end
                if (calib_done) begin
                    state_d   = StWrite;
                    wr_req_d  = 1'b1;
                    wr_addr_d = addr_d;
                    wr_data_d = pattern(16'(addr_d), 16'd0, parity_d);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (error_d) begin
            error_flag_d = 1'b1;
            if (error_cnt_q != 16'hFFFF) begin
                error_cnt_d = error_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            parity_q     <= 1'b0;
            wr_beat_q    <= '0;
            rd_beat_q    <= '0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_data_q    <= '0;
            error_q      <= 1'b0;
            error_flag_q <= 1'b0;
            error_cnt_q  <= '0;
            pass_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            parity_q     <= parity_d;
            wr_beat_q    <= wr_beat_d;
            rd_beat_q    <= rd_beat_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
            error_q      <= error_d;
            error_flag_q <= error_flag_d;
            error_cnt_q  <= error_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
        end
    end

    assign wr_burst_req  = wr_req_q;
    assign wr_burst_len  = 10'(BURST_LEN);
    assign wr_burst_addr = wr_addr_q;
    assign wr_burst_data = wr_data_q;
    assign rd_burst_req  = rd_req_q;
    assign rd_burst_len  = 10'(BURST_LEN);
    assign rd_burst_addr = rd_addr_q;
    assign error         = error_q;
    assign error_flag    = error_flag_q;
    assign error_cnt     = error_cnt_q;
    assign pass_cnt      = pass_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_ddr3_burst_tester.sv
// Randomized bench for ddr3_burst_tester: an ideal controller drives bursts while a
// burst-level reference model predicts patterns, error pulses and counters.
module tb_ddr3_burst_tester;

    localparam int BL    = 4;
    localparam int LIMIT = 8;
    localparam int DW    = 64;
    localparam int AW    = 24;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          calib_done;
    logic          wr_burst_req;
    logic [9:0]    wr_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic          wr_burst_data_req;
    logic [DW-1:0] wr_burst_data;
    logic          wr_burst_finish;
    logic          rd_burst_req;
    logic [9:0]    rd_burst_len;
    logic [AW-1:0] rd_burst_addr;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_finish;
    logic          error;
    logic          error_flag;
    logic [15:0]   error_cnt;
    logic [15:0]   pass_cnt;
    logic [1:0]    state;

    ddr3_burst_tester #(
        .MEM_DATA_BITS(DW),
        .ADDR_BITS    (AW),
        .BURST_LEN    (BL),
        .ADDR_LIMIT   (LIMIT)
    ) dut (
        .mem_clk            (mem_clk),
        .rst                (rst),
        .calib_done         (calib_done),
        .wr_burst_req       (wr_burst_req),
        .wr_burst_len       (wr_burst_len),
        .wr_burst_addr      (wr_burst_addr),
        .wr_burst_data_req  (wr_burst_data_req),
        .wr_burst_data      (wr_burst_data),
        .wr_burst_finish    (wr_burst_finish),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data      (rd_burst_data),
        .rd_burst_finish    (rd_burst_finish),
        .error              (error),
        .error_flag         (error_flag),
        .error_cnt          (error_cnt),
        .pass_cnt           (pass_cnt),
        .state              (state)
    );

    always #5 mem_clk = ~mem_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int unsigned m_addr;
    bit          m_par;
    int unsigned m_pass;
    int unsigned m_ecnt;
    bit          m_flag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_pat(input int unsigned a, input int unsigned k,
                                            input bit par);
        int unsigned w;
        w = ((a + k) % 65536) ^ (par ? 32'd65535 : 32'd0);
        return {4{w[15:0]}};
    endfunction

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic note_error();
        m_flag = 1'b1;
        if (m_ecnt < 65535) m_ecnt++;
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_par  = 0;
        m_pass = 0;
        m_ecnt = 0;
        m_flag = 0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_err_cnt"}, 64'(error_cnt), 64'(m_ecnt));
        check({tag, "_err_flag"}, 64'(error_flag), 64'(m_flag));
        check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(m_pass % 65536));
    endtask

    // Entered just after the edge on which wr_burst_req rose; leaves just after the
    // CHECK edge (or after returning from IDLE if calib_done was dropped).
    task automatic run_burst(input int nbeats, input int flip_beat, input bit coinc,
                             input bit drop_calib, input bit all_bad);
        bit e;
        bit len_err;
        check("wr_req_up", 64'(wr_burst_req), 64'd1);
        check("wr_addr", 64'(wr_burst_addr), 64'(m_addr));
        check("state_write", 64'(state), 64'd1);
        check("rd_req_idle", 64'(rd_burst_req), 64'd0);
        for (int k = 0; k < BL; k++) begin
            repeat ($urandom_range(0, 2)) step();
            check("wr_data", wr_burst_data, ref_pat(m_addr, k, m_par));
            wr_burst_data_req = 1'b1;
            step();
            wr_burst_data_req = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
            wr_burst_data_req = 1'b1;
            step();
            wr_burst_data_req = 1'b0;
        end
        repeat ($urandom_range(0, 2)) step();
        wr_burst_finish = 1'b1;
        check("wr_req_hold", 64'(wr_burst_req), 64'd1);
        step();
        wr_burst_finish = 1'b0;
        check("wr_req_drop", 64'(wr_burst_req), 64'd0);
        check("rd_req_up", 64'(rd_burst_req), 64'd1);
        check("rd_addr", 64'(rd_burst_addr), 64'(m_addr));
        check("state_read", 64'(state), 64'd2);

        for (int k = 0; k < nbeats; k++) begin
            if (!all_bad) repeat ($urandom_range(0, 2)) step();
            e = all_bad || (k == flip_beat);
            rd_burst_data_valid = 1'b1;
            rd_burst_data = all_bad ? ~ref_pat(m_addr, k, m_par)
                                    : ref_pat(m_addr, k, m_par) ^ 64'(e);
            if (coinc && k == nbeats - 1) rd_burst_finish = 1'b1;
            if (drop_calib && k == 0) calib_done = 1'b0;
            step();
            rd_burst_data_valid = 1'b0;
            rd_burst_finish = 1'b0;
            if (e) note_error();
            check("rd_err_pulse", 64'(error), 64'(e));
        end
        if (!coinc) begin
            repeat ($urandom_range(0, 2)) step();
            rd_burst_finish = 1'b1;
            step();
            rd_burst_finish = 1'b0;
            check("finish_no_err", 64'(error), 64'd0);
        end
        check("state_check", 64'(state), 64'd3);
        check("rd_req_drop", 64'(rd_burst_req), 64'd0);
        check("wr_req_in_check", 64'(wr_burst_req), 64'd0);

        len_err = (nbeats != BL);
        if (len_err) note_error();
        m_addr += BL;
        if (m_addr >= LIMIT) begin
            m_addr = 0;
            m_par  = ~m_par;
            m_pass++;
        end
        step();
        check("len_err_pulse", 64'(error), 64'(len_err));
        check_counters("post_check");
        if (drop_calib) begin
            check("idle_after_drop", 64'(state), 64'd0);
            check("no_req_after_drop", 64'(wr_burst_req), 64'd0);
            repeat ($urandom_range(1, 3)) step();
            check("idle_stays", 64'(state), 64'd0);
            calib_done = 1'b1;
            step();
        end
    endtask

    initial begin
        rst                 = 1'b1;
        calib_done          = 1'b0;
        wr_burst_data_req   = 1'b0;
        wr_burst_finish     = 1'b0;
        rd_burst_data_valid = 1'b0;
        rd_burst_data       = '0;
        rd_burst_finish     = 1'b0;
        model_reset();
        step();
        step();
        check("rst_state", 64'(state), 64'd0);
        check("rst_wr_req", 64'(wr_burst_req), 64'd0);
        check("rst_rd_req", 64'(rd_burst_req), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_wr_data", wr_burst_data, 64'd0);
        check("rst_wr_addr", 64'(wr_burst_addr), 64'd0);
        check("wr_len", 64'(wr_burst_len), 64'(BL));
        check("rd_len", 64'(rd_burst_len), 64'(BL));
        check_counters("rst");

        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("uncal_state", 64'(state), 64'd0);
            check("uncal_wr_req", 64'(wr_burst_req), 64'd0);
            check("uncal_rd_req", 64'(rd_burst_req), 64'd0);
        end
        calib_done = 1'b1;
        step();

        // Directed: two clean bursts wrap the region, then parity-inverted data.
        run_burst(BL, -1, 1'b0, 1'b0, 1'b0);
        check("second_addr", 64'(wr_burst_addr), 64'd4);
        run_burst(BL, -1, 1'b1, 1'b0, 1'b0);
        check("wrap_pass_cnt", 64'(pass_cnt), 64'd1);
        check("wrap_addr", 64'(wr_burst_addr), 64'd0);
        check("wrap_beat0", wr_burst_data, 64'hFFFF_FFFF_FFFF_FFFF);
        run_burst(BL, 2, 1'b0, 1'b0, 1'b0);
        check("flip_err_cnt", 64'(error_cnt), 64'd1);
        run_burst(BL - 1, -1, 1'b0, 1'b0, 1'b0);
        run_burst(BL, -1, 1'b1, 1'b0, 1'b0);
        check("flag_sticky", 64'(error_flag), 64'd1);

        for (int i = 0; i < 30; i++) begin
            run_burst(($urandom_range(0, 5) == 0) ? BL - 1 : BL,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BL - 2)) : -1,
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0),
                      1'b0);
        end

        // Reset in the middle of a write burst.
        wr_burst_data_req = 1'b1;
        step();
        wr_burst_data_req = 1'b0;
        rst = 1'b1;
        step();
        model_reset();
        check("midrst_wr_req", 64'(wr_burst_req), 64'd0);
        check("midrst_state", 64'(state), 64'd0);
        check_counters("midrst");
        rst = 1'b0;
        step();
        run_burst(BL, -1, 1'b0, 1'b0, 1'b0);

        // Saturate the error counter with a long stream of bad beats.
        run_burst(65541, -1, 1'b0, 1'b0, 1'b1);
        check("err_cnt_sat", 64'(error_cnt), 64'hFFFF);
        run_burst(BL, 1, 1'b0, 1'b0, 1'b0);
        check("err_cnt_sat_hold", 64'(error_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
